// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - per-candidate saturating vote tally with acknowledge lockout
// Purpose: accepts one-cycle vote pulses, keeps one saturating tally per candidate,
//   locks out further votes for ACK_CYCLES cycles after each accepted vote, and
//   shows a selected tally in result mode.
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous, active-high reset
//   valid_vote  one-cycle vote pulses, bit i = candidate i
//   mode        0 = voting, 1 = result display
//   sel         candidate index shown in result mode
//   result      registered tally of candidate sel (0 outside result mode)
//   ack_led     one-hot accepted candidate, lit during the acknowledge window
//   multi_err   one-cycle pulse on an ambiguous (multi-bit) press
//   busy        high while the acknowledge window runs
//   total       only with VOTE_TALLY_TOTAL_EN: saturating sum of accepted votes
module vote_tally #(
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 8,
  parameter int ACK_CYCLES = 100
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CAND-1:0]           valid_vote,
  input  logic                          mode,
  input  logic [$clog2(NUM_CAND)-1:0]   sel,
  output logic [CNT_W-1:0]              result,
  output logic [NUM_CAND-1:0]           ack_led,
  output logic                          multi_err,
  output logic                          busy
`ifdef VOTE_TALLY_TOTAL_EN
  ,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0] total
`endif
);

  localparam int SEL_W = $clog2(NUM_CAND);
  localparam int CW    = $clog2(NUM_CAND + 1);
  localparam int TMR_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACK, RESULT} state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [NUM_CAND-1:0] ack_n;
  logic               busy_n, err_n, accept;
  logic [CNT_W-1:0]   result_n, sel_tally;
  logic [CW-1:0]      vote_cnt;
  logic [SEL_W-1:0]   vote_idx;
  logic [CNT_W-1:0]   tally [NUM_CAND];

  // Population count of the pulses plus the index of the (last) set bit; the
  // index is only used when the count is exactly one.
  always_comb begin
    vote_cnt = '0;
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (valid_vote[i]) begin
        vote_cnt = vote_cnt + CW'(1);
        vote_idx = SEL_W'(i);
      end
    end
  end

  // Out-of-range sel (non power-of-two NUM_CAND) matches nothing and reads 0.
  always_comb begin
    sel_tally = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (sel == SEL_W'(i)) sel_tally = tally[i];
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    ack_n    = ack_led;
    busy_n   = busy;
    err_n    = 1'b0;
    result_n = '0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          state_n = RESULT;
        end else if (vote_cnt == CW'(1)) begin
          accept  = 1'b1;
          state_n = ACK;
          ack_n   = NUM_CAND'(1) << vote_idx;
          busy_n  = 1'b1;
          timer_n = TMR_W'(ACK_CYCLES - 1);
        end else if (vote_cnt > CW'(1)) begin
          err_n = 1'b1;
        end
      end
      ACK: begin
        if (timer == '0) begin
          state_n = IDLE;
          ack_n   = '0;
          busy_n  = 1'b0;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      RESULT: begin
        if (mode) result_n = sel_tally;
        else      state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      ack_led   <= '0;
      busy      <= 1'b0;
      multi_err <= 1'b0;
      result    <= '0;
    end else begin
      timer     <= timer_n;
      ack_led   <= ack_n;
      busy      <= busy_n;
      multi_err <= err_n;
      result    <= result_n;
    end
  end

  // Tallies hold at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (accept && vote_idx == SEL_W'(i) && tally[i] != '1)
          tally[i] <= tally[i] + CNT_W'(1);
      end
    end
  end

`ifdef VOTE_TALLY_TOTAL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      total <= '0;
    else if (accept && total != '1) total <= total + (CNT_W+SEL_W)'(1);
  end
`endif

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed scoreboard bench for vote_tally
module tb_vote_tally;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] valid_vote;
  logic       mode;
  logic [1:0] sel;
  logic [7:0] result;
  logic [3:0] ack_led;
  logic       multi_err;
  logic       busy;

  logic [3:0] vv2;
  logic       mode2;
  logic [1:0] sel2;
  logic [1:0] result2;
  logic [3:0] ack2;
  logic       err2;
  logic       busy2;

`ifdef VOTE_TALLY_TOTAL_EN
  logic [9:0] total;
  logic [3:0] total2;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  int exp_q[$];
  int mdl[4];

  always #5 clock = ~clock;

  vote_tally #(.NUM_CAND(4), .CNT_W(8), .ACK_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .valid_vote(valid_vote), .mode(mode), .sel(sel),
    .result(result), .ack_led(ack_led), .multi_err(multi_err), .busy(busy)
`ifdef VOTE_TALLY_TOTAL_EN
    , .total(total)
`endif
  );

  vote_tally #(.NUM_CAND(4), .CNT_W(2), .ACK_CYCLES(3)) dut2 (
    .clock(clock), .reset(reset), .valid_vote(vv2), .mode(mode2), .sel(sel2),
    .result(result2), .ack_led(ack2), .multi_err(err2), .busy(busy2)
`ifdef VOTE_TALLY_TOTAL_EN
    , .total(total2)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_vote(input logic [3:0] v);
    valid_vote = v;
    tick();
    valid_vote = '0;
  endtask

  // Runs out the acknowledge window with a bound; returns cycles busy was seen high.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      cycles++;
      tick();
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Result-mode read: expectation queued at stimulus time, popped when result is due.
  task automatic res_sel(input int s);
    sel = 2'(s);
    exp_q.push_back(mdl[s]);
    tick();
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check($sformatf("result_sel%0d", s), 32'(result), 32'(exp_q.pop_front()));
  endtask

  task automatic read_all();
    mode = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) res_sel(s);
    mode = 1'b0;
    tick();
    check("result_cleared_on_exit", 32'(result), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; valid_vote = '0; mode = 1'b0; sel = '0;
    vv2 = '0; mode2 = 1'b0; sel2 = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    tick(); tick();
    check("rst_result", 32'(result), 32'd0);
    check("rst_ack_led", 32'(ack_led), 32'd0);
    check("rst_multi_err", 32'(multi_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // single vote for candidate 1 and the full acknowledge window
    do_vote(4'b0010);
    mdl[1]++;
    check("vote1_ack_led", 32'(ack_led), 32'd2);
    check("vote1_busy", 32'(busy), 32'd1);
    wait_idle(cyc);
    check("busy_length", 32'(cyc), 32'd100);
    check("ack_led_cleared", 32'(ack_led), 32'd0);
    mode = 1'b1;
    tick();
    check("result_first_result_cycle", 32'(result), 32'd0);
    res_sel(1);
    res_sel(0);
    mode = 1'b0;
    tick();
    check("result_zero_in_idle", 32'(result), 32'd0);

    // ambiguous press
    do_vote(4'b0101);
    check("multi_err_pulse", 32'(multi_err), 32'd1);
    check("multi_busy", 32'(busy), 32'd0);
    check("multi_ack_led", 32'(ack_led), 32'd0);
    tick();
    check("multi_err_one_cycle", 32'(multi_err), 32'd0);

    // lockout: candidate 0 pulse mid-window is ignored
    do_vote(4'b1000);
    mdl[3]++;
    repeat (49) tick();
    do_vote(4'b0001);
    check("lockout_ack_led", 32'(ack_led), 32'd8);
    check("lockout_no_err", 32'(multi_err), 32'd0);
    do_vote(4'b0011);
    check("lockout_multi_ignored", 32'(multi_err), 32'd0);
    wait_idle(cyc);
    do_vote(4'b1000);
    mdl[3]++;
    check("vote3_again_ack", 32'(ack_led), 32'd8);
    wait_idle(cyc);
    read_all();

    // mode has priority over a simultaneous vote
    mode = 1'b1;
    valid_vote = 4'b0001;
    tick();
    valid_vote = '0;
    check("mode_prio_busy", 32'(busy), 32'd0);
    check("mode_prio_ack", 32'(ack_led), 32'd0);
    res_sel(0);
    mode = 1'b0;
    tick();

    // asynchronous reset in the middle of an acknowledge window
    do_vote(4'b0100);
    repeat (5) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ack_led", 32'(ack_led), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    tick();
    reset = 1'b0;
    tick();
    read_all();

    // CNT_W=2 instance saturates at 3
    for (int k = 0; k < 5; k++) begin
      vv2 = 4'b0100;
      tick();
      vv2 = '0;
      repeat (5) tick();
      if (k == 2) check("sat_ack_led", 32'(ack2), 32'd0);
    end
    mode2 = 1'b1;
    sel2 = 2'd2;
    tick();
    tick();
    check("saturated_tally", 32'(result2), 32'd3);
    mode2 = 1'b0;
    tick();

`ifdef VOTE_TALLY_TOTAL_EN
    check("total_start", 32'(total), 32'd0);
    do_vote(4'b0001); wait_idle(cyc);
    do_vote(4'b0010);
    check("total_same_cycle", 32'(total), 32'd2);
    wait_idle(cyc);
    do_vote(4'b0010); wait_idle(cyc);
    do_vote(4'b1000); wait_idle(cyc);
    check("total_four", 32'(total), 32'd4);
    check("total2_sat", 32'(total2), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
